// File: rtl/boss_proj_pool.sv
// Boss projectile pool: fixed slots with lowest-free allocation, downward motion, hit/despawn retirement.
// Optional X homing toward the player is enabled with macro BOSS_PROJ_HOMING_EN.
module boss_proj_pool #(
    parameter int NUM_PROJ = 8,
    parameter int STEP_Y   = 4,
    parameter int SCREEN_H = 480
) (
    input  logic                   clk,
    input  logic                   sw,
    input  logic                   move_pulse,
    input  logic                   spawn_req,
    input  logic [9:0]             spawn_x,
    input  logic [8:0]             spawn_y,
    input  logic [9:0]             target_x,
    input  logic                   hit_valid,
    input  logic [3:0]             hit_idx,
    output logic                   spawn_ack,
    output logic                   spawn_drop,
    output logic [NUM_PROJ*10-1:0] proj_x,
    output logic [NUM_PROJ*9-1:0]  proj_y,
    output logic [NUM_PROJ-1:0]    active,
    output logic [4:0]             active_count
);

    localparam logic [9:0] PARK_X = 10'h3FF;
    localparam logic [8:0] PARK_Y = 9'h1FF;

    logic [NUM_PROJ-1:0] active_q, active_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                drop_q, drop_d;
    logic [9:0]          x_q [NUM_PROJ];
    logic [9:0]          x_d [NUM_PROJ];
    logic [8:0]          y_q [NUM_PROJ];
    logic [8:0]          y_d [NUM_PROJ];
    logic [9:0]          y_step [NUM_PROJ];
    logic [3:0]          alloc_idx;
    logic                full;
    logic                accept;

`ifdef BOSS_PROJ_HOMING_EN
    function automatic logic [9:0] home_step(input logic [9:0] x, input logic [9:0] tgt);
        logic [9:0] r;
        r = x;
        if (x < tgt && x < 10'd639)
            r = x + 10'd1;
        else if (x > tgt && x > 10'd0)
            r = x - 10'd1;
        return r;
    endfunction
`else
    logic unused_target;
    assign unused_target = ^target_x;
`endif

    // Widened to 10 bits so a Y near 511 cannot wrap below the boundary.
    always_comb begin
        for (int i = 0; i < NUM_PROJ; i++)
            y_step[i] = {1'b0, y_q[i]} + 10'(STEP_Y);
    end

    always_comb begin
        full      = &active_q;
        alloc_idx = '0;
        for (int i = NUM_PROJ - 1; i >= 0; i--)
            if (!active_q[i]) alloc_idx = 4'(i);
        accept    = spawn_req && !full;
        ack_d     = accept;
        drop_d    = spawn_req && full;
        active_d  = active_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = '0;

        for (int i = 0; i < NUM_PROJ; i++) begin
            if (active_q[i]) begin
                if (hit_valid && hit_idx == 4'(i)) begin
                    active_d[i] = 1'b0;
                end else if (move_pulse) begin
                    if (y_step[i] >= 10'(SCREEN_H)) begin
                        active_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_step[i][8:0];
`ifdef BOSS_PROJ_HOMING_EN
                        x_d[i] = home_step(x_q[i], target_x);
`endif
                    end
                end
            end else if (accept && alloc_idx == 4'(i)) begin
                // Freshly spawned slots skip this cycle's move.
                active_d[i] = 1'b1;
                x_d[i]      = spawn_x;
                y_d[i]      = spawn_y;
            end
        end

        for (int i = 0; i < NUM_PROJ; i++)
            cnt_d = cnt_d + 5'(active_d[i]);
    end

    always_ff @(posedge clk or negedge sw) begin
        if (!sw) begin
            active_q <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            drop_q   <= drop_d;
        end
    end

    // Coordinates need no reset: they are masked by active_q on the outputs.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

    for (genvar g = 0; g < NUM_PROJ; g++) begin : g_out
        assign proj_x[g*10 +: 10] = active_q[g] ? x_q[g] : PARK_X;
        assign proj_y[g*9 +: 9]   = active_q[g] ? y_q[g] : PARK_Y;
    end

    assign active       = active_q;
    assign active_count = cnt_q;
    assign spawn_ack    = ack_q;
    assign spawn_drop   = drop_q;

endmodule

// File: tb/tb_boss_proj_pool.sv
// Directed self-checking bench for boss_proj_pool (default parameters).
module tb_boss_proj_pool;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          sw;
    logic          move_pulse, spawn_req, hit_valid;
    logic [9:0]    spawn_x, target_x;
    logic [8:0]    spawn_y;
    logic [3:0]    hit_idx;
    logic          spawn_ack, spawn_drop;
    logic [N*10-1:0] proj_x;
    logic [N*9-1:0]  proj_y;
    logic [N-1:0]  active;
    logic [4:0]    active_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [N*10-1:0] exp_x;
    logic [N*9-1:0]  exp_y;

    boss_proj_pool #(.NUM_PROJ(N), .STEP_Y(4), .SCREEN_H(480)) dut (
        .clk(clk), .sw(sw), .move_pulse(move_pulse), .spawn_req(spawn_req),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .target_x(target_x),
        .hit_valid(hit_valid), .hit_idx(hit_idx),
        .spawn_ack(spawn_ack), .spawn_drop(spawn_drop),
        .proj_x(proj_x), .proj_y(proj_y), .active(active), .active_count(active_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic spawn(input logic [9:0] x, input logic [8:0] y, input logic mv);
        spawn_req = 1'b1; spawn_x = x; spawn_y = y; move_pulse = mv;
        cyc();
        spawn_req = 1'b0; move_pulse = 1'b0;
    endtask

    task automatic hit(input logic [3:0] idx, input logic mv);
        hit_valid = 1'b1; hit_idx = idx; move_pulse = mv;
        cyc();
        hit_valid = 1'b0; move_pulse = 1'b0;
    endtask

    task automatic move();
        move_pulse = 1'b1;
        cyc();
        move_pulse = 1'b0;
    endtask

    function automatic logic [9:0] sx(input int i);
        return proj_x[i*10 +: 10];
    endfunction

    function automatic logic [8:0] sy(input int i);
        return proj_y[i*9 +: 9];
    endfunction

    initial begin
        sw = 1'b0; move_pulse = 1'b0; spawn_req = 1'b0; hit_valid = 1'b0;
        spawn_x = '0; spawn_y = '0; target_x = '0; hit_idx = '0;

        // Reset state
        repeat (3) cyc();
        chk("rst_active", 80'(active), 80'h0);
        chk("rst_count", 80'(active_count), 80'd0);
        chk("rst_px", 80'(proj_x), {80{1'b1}});
        chk("rst_py", 80'(proj_y), 80'({72{1'b1}}));
        chk("rst_ack", 80'(spawn_ack), 80'd0);
        chk("rst_drop", 80'(spawn_drop), 80'd0);
        sw = 1'b1;

        // Fill all slots at (100,20)
        for (int i = 0; i < N; i++) begin
            spawn(10'd100, 9'd20, 1'b0);
            chk($sformatf("fill_ack%0d", i), 80'(spawn_ack), 80'd1);
            chk($sformatf("fill_act%0d", i), 80'(active), 80'((1 << (i + 1)) - 1));
        end
        for (int i = 0; i < N; i++) begin
            exp_x[i*10 +: 10] = 10'd100;
            exp_y[i*9 +: 9]   = 9'd20;
        end
        chk("fill_count", 80'(active_count), 80'd8);
        chk("fill_px", 80'(proj_x), 80'(exp_x));
        chk("fill_py", 80'(proj_y), 80'(exp_y));

        // Ninth spawn is dropped with no state change
        spawn(10'd300, 9'd40, 1'b0);
        chk("full_drop", 80'(spawn_drop), 80'd1);
        chk("full_ack", 80'(spawn_ack), 80'd0);
        chk("full_act", 80'(active), 80'hFF);
        chk("full_px", 80'(proj_x), 80'(exp_x));

        // Hit on slot 3 with spawn in the same cycle: freed slot not yet allocatable
        spawn_req = 1'b1; spawn_x = 10'd300; spawn_y = 9'd40;
        hit(4'd3, 1'b0);
        spawn_req = 1'b0;
        chk("hitspawn_drop", 80'(spawn_drop), 80'd1);
        chk("hitspawn_act", 80'(active), 80'hF7);
        chk("hitspawn_cnt", 80'(active_count), 80'd7);
        chk("hit3_park_x", 80'(sx(3)), 80'h3FF);
        chk("hit3_park_y", 80'(sy(3)), 80'h1FF);
        spawn(10'd300, 9'd40, 1'b0);
        chk("refill_ack", 80'(spawn_ack), 80'd1);
        chk("refill_act", 80'(active), 80'hFF);
        chk("refill_x3", 80'(sx(3)), 80'd300);
        chk("refill_y3", 80'(sy(3)), 80'd40);

        // Out-of-range hit is ignored
        hit(4'd9, 1'b0);
        chk("hit_oor_act", 80'(active), 80'hFF);

        // Trim to 5 active, then assert reset mid-cycle
        hit(4'd7, 1'b0);
        hit(4'd6, 1'b0);
        hit(4'd5, 1'b0);
        chk("five_act", 80'(active), 80'h1F);
        chk("five_cnt", 80'(active_count), 80'd5);
        #2;
        sw = 1'b0;
        spawn_req = 1'b1; move_pulse = 1'b1;
        #1;
        chk("midrst_act", 80'(active), 80'h0);
        chk("midrst_cnt", 80'(active_count), 80'd0);
        chk("midrst_px", 80'(proj_x), {80{1'b1}});
        chk("midrst_py", 80'(proj_y), 80'({72{1'b1}}));
        cyc();
        spawn_req = 1'b0; move_pulse = 1'b0;
        chk("inrst_act", 80'(active), 80'h0);
        chk("inrst_ack", 80'(spawn_ack), 80'd0);
        sw = 1'b1;

        // Despawn boundary (476+4=480 leaves, 475+4=479 stays, 510 must not wrap)
        spawn(10'd50, 9'd476, 1'b0);
        chk("post_rst_ack", 80'(spawn_ack), 80'd1);
        spawn(10'd60, 9'd470, 1'b0);
        spawn(10'd70, 9'd475, 1'b0);
        spawn(10'd80, 9'd510, 1'b0);
        chk("desp_pre_act", 80'(active), 80'h0F);
        move();
        chk("desp_act", 80'(active), 80'h06);
        chk("desp_cnt", 80'(active_count), 80'd2);
        chk("desp_park_x0", 80'(sx(0)), 80'h3FF);
        chk("desp_park_y0", 80'(sy(0)), 80'h1FF);
        chk("desp_y1", 80'(sy(1)), 80'd474);
        chk("desp_y2", 80'(sy(2)), 80'd479);
        chk("desp_park_y3", 80'(sy(3)), 80'h1FF);
        move();
        chk("desp2_act", 80'(active), 80'h02);
        chk("desp2_y1", 80'(sy(1)), 80'd478);

        // Spawn coinciding with move: new slot unmoved, old slot moves
        sw = 1'b0;
        cyc();
        sw = 1'b1;
        spawn(10'd10, 9'd100, 1'b0);
        spawn(10'd20, 9'd50, 1'b1);
        chk("sim_ack", 80'(spawn_ack), 80'd1);
        chk("sim_act", 80'(active), 80'h03);
        chk("sim_y0", 80'(sy(0)), 80'd104);
        chk("sim_y1", 80'(sy(1)), 80'd50);
        chk("sim_x1", 80'(sx(1)), 80'd20);

        // Hit and move on the same slot: hit wins
        hit(4'd0, 1'b1);
        chk("hitmove_act", 80'(active), 80'h02);
        chk("hitmove_y1", 80'(sy(1)), 80'd54);

        // Hit on inactive slot 0 alongside a spawn: spawn lands, hit ignored
        spawn_req = 1'b1; spawn_x = 10'd200; spawn_y = 9'd100;
        hit(4'd0, 1'b0);
        spawn_req = 1'b0;
        chk("hit_inact_act", 80'(active), 80'h03);
        chk("hit_inact_x0", 80'(sx(0)), 80'd200);

        // Homing: X=200 toward target 205 over three pulses
        target_x = 10'd205;
        repeat (3) move();
`ifdef BOSS_PROJ_HOMING_EN
        chk("home_x0", 80'(sx(0)), 80'd203);
`else
        chk("home_x0", 80'(sx(0)), 80'd200);
`endif
        chk("home_y0", 80'(sy(0)), 80'd112);
        chk("home_cnt", 80'(active_count), 80'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
